// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the bit-serial add/subtract unit:
//     - state_t    : FSM state encoding (ST_IDLE = 1'b0, ST_RUN = 1'b1)
//     - MODE_ADD / MODE_SUB : values of the 'sub' request input
//     - cnt_width(): width of the bit counter for a given operand width
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // The counter only has to reach WIDTH-1, so $clog2(WIDTH) bits are enough;
    // clamp to one bit so a degenerate width never yields a zero-width vector.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// -----------------------------------------------------------------------------
// full_adder_cell
//   Single-bit combinational full adder; the only arithmetic in serial_adder.
//   Ports:
//     a, b  in  1  operand bits
//     cin   in  1  carry in
//     s     out 1  sum bit
//     cout  out 1  carry out
// -----------------------------------------------------------------------------
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial add/subtract unit. Two WIDTH-bit operands are processed LSB
//   first, one bit per clock, through one full_adder_cell and a carry flop.
//   Subtraction is a + ~b + 1 (operand B inverted at load, carry preset to 1).
//
//   Parameters:
//     WIDTH  operand/result width, 2..32 (default 8)
//
//   Ports:
//     clk    in   1      rising-edge clock
//     rst_n  in   1      asynchronous active-low reset
//     start  in   1      request, sampled only while idle
//     sub    in   1      0: a+b, 1: a-b (sampled with start)
//     a, b   in   WIDTH  operands (sampled with start)
//     busy   out  1      high while bits are being processed
//     done   out  1      one-cycle pulse, results valid from this cycle
//     sum    out  WIDTH  result, held until the next completed operation
//     cout   out  1      add: carry out; sub: no-borrow (a >= b unsigned)
//     ovf    out  1      signed overflow
//
//   Build option:
//     SERIAL_ADDER_OVF_EN  defined  : ovf registered as (carry into MSB) ^ (carry
//                                     out of MSB) on the last bit.
//                          undefined: ovf tied low, no flop.
//
//   Timing: start sampled at edge N, done high in the cycle after edge N+WIDTH.
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
        $error("serial_adder: WIDTH must be in 2..32");
    end

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Holds the WIDTH-1 result bits produced so far; the last bit comes
    // straight from the adder when sum is loaded.
    logic [WIDTH-2:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_co;

    full_adder_cell u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_co)
    );

    // NOTE: state is updated with non-blocking assignments only, so every
    // right-hand side in this block sees the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the operand/result shift registers are reset as well; they
            // are few flops and a reset mid-operation must leave no residue.
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b ^ {WIDTH{sub == MODE_SUB}};
                        carry <= (sub == MODE_SUB);
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    // New sum bit enters at the top and moves down each cycle.
                    res_sh <= (WIDTH-1)'({fa_s, res_sh} >> 1);
                    carry  <= fa_co;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        sum   <= {fa_s, res_sh};
                        cout  <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry still holds the carry into the MSB here.
                        ovf   <= carry ^ fa_co;
`endif
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf = 1'b0;
`endif

endmodule
